itr_ctrl: RTL and testbench



---
 rtl/itr_ctrl_pkg.sv | 19 +
 rtl/itr_ctrl_prio_enc.sv | 27 ++
 rtl/itr_ctrl.sv | 120 ++++++++++++
 tb/tb_itr_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itr_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package itr_ctrl_pkg;

   // Controller states; encodings are fixed so they read the same in waveforms.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      WAIT = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Width of an index/address over n values, never narrower than one bit.
   function automatic int w_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/itr_ctrl_prio_enc.sv
// Lowest-index priority encoder.
// Latency: combinational.
// Backpressure: none.
// Ports: req (request vector), valid (any request set), idx (lowest set index).
module prio_enc
   import itr_ctrl_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   output logic                 valid,
   output logic [w_of(N)-1:0]   idx
);

   localparam int IW = w_of(N);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt sequencer: edge-detects requests, fires one itr pulse per source, retires on ID read.
// Latency: irq rise to itr high is two clk edges; itr pulses are spaced at least 2+GAPCYC cycles.
// Backpressure: a source stays pending until acknowledged; repeat edges while pending set ovf.
// Ports: clk/rst; irq request lines; snooped processor I/O bus (io_out, addr_out, out_en,
//        addr_in, req_in); itr pulse, id_data (source in service), busy, ovf (sticky lost edges).
module itr_ctrl
   import itr_ctrl_pkg::*;
#(
   parameter int NUITRS = 4,
   parameter int NUBITS = 16,
   parameter int NUIOIN = 2,
   parameter int NUIOOU = 2,
   parameter int ADDRID = 0,
   parameter int ADDRMK = 0,
   parameter int GAPCYC = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUITRS-1:0]         irq,
   input  logic [NUBITS-1:0]         io_out,
   input  logic [w_of(NUIOOU)-1:0]   addr_out,
   input  logic                      out_en,
   input  logic [w_of(NUIOIN)-1:0]   addr_in,
   input  logic                      req_in,
   output logic                      itr,
   output logic [NUBITS-1:0]         id_data,
   output logic                      busy,
   output logic [NUITRS-1:0]         ovf
);

   localparam int IDW = w_of(NUITRS);
   localparam int AIW = w_of(NUIOIN);
   localparam int AOW = w_of(NUIOOU);
   localparam int CW  = w_of(GAPCYC + 1);
   localparam logic [AIW-1:0] A_ID    = AIW'(ADDRID);
   localparam logic [AOW-1:0] A_MK    = AOW'(ADDRMK);
   localparam bit             HAS_GAP = (GAPCYC > 0);
   localparam logic [CW-1:0]  GAP_LD  = CW'((GAPCYC > 0) ? GAPCYC - 1 : 0);

   state_t              state, state_n;
   logic [NUITRS-1:0]   irq_q, pending, mask;
   logic [NUITRS-1:0]   rise, elig, clr;
   logic [IDW-1:0]      id, win_idx;
   logic                win_vld;
   logic [CW-1:0]       cnt, cnt_n;
   logic                ack, load, retire;
   logic                unused_io;

   // Only the low NUITRS bits of the output bus form the mask.
   assign unused_io = ^io_out;

   assign rise = irq & ~irq_q;
   assign elig = pending & mask;
   assign ack  = req_in && (addr_in == A_ID);
   assign clr  = retire ? (NUITRS'(1) << id) : '0;

   prio_enc #(.N(NUITRS)) u_prio (
      .req   (elig),
      .valid (win_vld),
      .idx   (win_idx)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      retire  = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_vld) begin
               load    = 1'b1;
               state_n = FIRE;
            end
         end
         FIRE, WAIT: begin
            if (ack) retire  = 1'b1;
            else     state_n = WAIT;
         end
         GAP: begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (retire) begin
         if (HAS_GAP) begin
            state_n = GAP;
            cnt_n   = GAP_LD;
         end else begin
            state_n = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         irq_q   <= '0;
         pending <= '0;
         mask    <= '0;
         ovf     <= '0;
         id      <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         irq_q   <= irq;
         // A new edge survives a same-cycle retire so it is served again.
         pending <= (pending & ~clr) | rise;
         ovf     <= ovf | (rise & pending);
         if (out_en && (addr_out == A_MK)) mask <= io_out[NUITRS-1:0];
         if (load) id <= win_idx;
      end
   end

   assign itr     = (state == FIRE);
   assign busy    = (state != IDLE);
   assign id_data = NUBITS'(id);

endmodule

// File: tb/tb_itr_ctrl.sv
module tb_itr_ctrl;

   localparam int NUITRS = 4;
   localparam int NUBITS = 16;
   localparam int GAPCYC = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        irq;
   logic [15:0]       io_out;
   logic [0:0]        addr_out;
   logic              out_en;
   logic [0:0]        addr_in;
   logic              req_in;
   logic              itr;
   logic [15:0]       id_data;
   logic              busy;
   logic [3:0]        ovf;

   int checks = 0;
   int errors = 0;

   itr_ctrl #(
      .NUITRS(NUITRS), .NUBITS(NUBITS), .NUIOIN(2), .NUIOOU(2),
      .ADDRID(0), .ADDRMK(0), .GAPCYC(GAPCYC)
   ) dut (
      .clk(clk), .rst(rst), .irq(irq), .io_out(io_out), .addr_out(addr_out),
      .out_en(out_en), .addr_in(addr_in), .req_in(req_in), .itr(itr),
      .id_data(id_data), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: tracks whether a source is being fired, awaiting its read,
   // and how many hold-off cycles remain, following the behavioural rules directly.
   logic [3:0] m_irq_q, m_pend, m_mask, m_ovf, m_rise, m_elig, m_clr;
   bit         m_fire, m_wait;
   int         m_gap, m_id;

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_irq_q = '0; m_pend = '0; m_mask = '0; m_ovf = '0;
         m_fire = 0; m_wait = 0; m_gap = 0; m_id = 0;
      end else begin
         m_rise = irq & ~m_irq_q;
         m_ovf  = m_ovf | (m_rise & m_pend);
         m_elig = m_pend & m_mask;
         m_clr  = '0;
         if (m_fire || m_wait) begin
            if (req_in && addr_in == 1'b0) begin
               m_clr[m_id] = 1'b1;
               m_fire = 0; m_wait = 0; m_gap = GAPCYC;
            end else if (m_fire) begin
               m_fire = 0; m_wait = 1;
            end
         end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
         end else if (m_elig != 0) begin
            m_id = lowest(m_elig);
            m_fire = 1;
         end
         m_pend = (m_pend & ~m_clr) | m_rise;
         if (out_en && addr_out == 1'b0) m_mask = io_out[3:0];
         m_irq_q = irq;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic write_mask(input logic [3:0] m);
      out_en = 1'b1; addr_out = 1'b0; io_out = {12'h0, m};
      step();
      out_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; irq = '0; io_out = '0; addr_out = '0; out_en = 1'b0;
      addr_in = '0; req_in = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if ({itr, busy, id_data, ovf} !== 22'd0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: itr=%b busy=%b id=%0d ovf=%b, want all zero",
                     k, itr, busy, id_data, ovf);
         end
      end
   endtask

   task automatic test_single();
      write_mask(4'b1111);
      irq = 4'b0100;
      step();
      checks++;
      if (itr !== 1'b0) begin errors++; $display("FAIL single_early itr=%b want 0", itr); end
      step();
      checks++;
      if (itr !== 1'b1 || id_data !== 16'd2) begin
         errors++; $display("FAIL single_fire itr=%b id=%0d want 1/2", itr, id_data);
      end
      step();
      checks++;
      if (itr !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_wait itr=%b busy=%b want 0/1", itr, busy);
      end
      repeat (3) step();
      req_in = 1'b1; addr_in = 1'b0;
      step();
      req_in = 1'b0;
      for (int k = 0; k <= GAPCYC; k++) begin
         checks++;
         if (busy !== (k < GAPCYC)) begin
            errors++; $display("FAIL single_gap k=%0d busy=%b want %b", k, busy, k < GAPCYC);
         end
         if (k < GAPCYC) step();
      end
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (itr !== 1'b0) begin errors++; $display("FAIL single_held k=%0d itr=%b want 0", k, itr); end
      end
      irq = '0;
      step();
   endtask

   task automatic test_priority();
      int n;
      irq = 4'b1010;
      step(); step();
      checks++;
      if (itr !== 1'b1 || id_data !== 16'd1) begin
         errors++; $display("FAIL prio_first itr=%b id=%0d want 1/1", itr, id_data);
      end
      req_in = 1'b1; addr_in = 1'b0;
      step();
      req_in = 1'b0;
      n = 0;
      while (itr !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (itr !== 1'b1 || id_data !== 16'd3 || n != GAPCYC + 1) begin
         errors++; $display("FAIL prio_second itr=%b id=%0d after %0d cyc, want 1/3 after %0d",
                            itr, id_data, n, GAPCYC + 1);
      end
      req_in = 1'b1;
      step();
      req_in = 1'b0; irq = '0;
      repeat (6) step();
   endtask

   task automatic test_masking();
      write_mask(4'b0001);
      irq = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (itr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mask_block k=%0d itr=%b busy=%b want 0/0", k, itr, busy);
         end
      end
      write_mask(4'b0100);
      checks++;
      if (itr !== 1'b0) begin errors++; $display("FAIL mask_early itr=%b want 0", itr); end
      step();
      checks++;
      if (itr !== 1'b1 || id_data !== 16'd2) begin
         errors++; $display("FAIL mask_open itr=%b id=%0d want 1/2", itr, id_data);
      end
      req_in = 1'b1;
      step();
      req_in = 1'b0; irq = '0;
      repeat (6) step();
   endtask

   task automatic test_overflow();
      int n;
      write_mask(4'b1111);
      irq = 4'b0001; step(); step();
      checks++;
      if (itr !== 1'b1 || ovf !== 4'b0000) begin
         errors++; $display("FAIL ovf_pre itr=%b ovf=%b want 1/0000", itr, ovf);
      end
      irq = '0; step();
      irq = 4'b0001; step();
      checks++;
      if (ovf !== 4'b0001) begin errors++; $display("FAIL ovf_set ovf=%b want 0001", ovf); end
      req_in = 1'b1; step();
      req_in = 1'b0; irq = '0;
      for (int k = 0; k < 7; k++) begin
         step();
         checks++;
         if (itr !== 1'b0) begin errors++; $display("FAIL ovf_merged k=%0d itr=%b want 0", k, itr); end
      end
      irq = 4'b0001; step(); step();
      irq = '0; step();
      req_in = 1'b1; irq = 4'b0001;
      step();
      req_in = 1'b0;
      n = 0;
      while (itr !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (itr !== 1'b1 || id_data !== 16'd0 || n != GAPCYC + 1 || ovf !== 4'b0001) begin
         errors++; $display("FAIL ovf_reserve itr=%b id=%0d n=%0d ovf=%b want 1/0/%0d/0001",
                            itr, id_data, n, ovf, GAPCYC + 1);
      end
      req_in = 1'b1; step();
      req_in = 1'b0; irq = '0;
      repeat (6) step();
   endtask

   task automatic test_reset_mid();
      irq = 4'b0010; step(); step();
      irq = '0; step();
      checks++;
      if (busy !== 1'b1 || itr !== 1'b0) begin
         errors++; $display("FAIL rstmid_wait busy=%b itr=%b want 1/0", busy, itr);
      end
      rst = 1'b1; step();
      rst = 1'b0;
      checks++;
      if ({itr, busy, id_data, ovf} !== 22'd0) begin
         errors++; $display("FAIL rstmid_regs itr=%b busy=%b id=%0d ovf=%b want zero",
                            itr, busy, id_data, ovf);
      end
      write_mask(4'b1111);
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (itr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet k=%0d itr=%b busy=%b want 0/0", k, itr, busy);
         end
      end
      irq = 4'b0010; step(); step();
      checks++;
      if (itr !== 1'b1 || id_data !== 16'd1) begin
         errors++; $display("FAIL rstmid_fresh itr=%b id=%0d want 1/1", itr, id_data);
      end
      req_in = 1'b1; step();
      req_in = 1'b0; irq = '0;
      repeat (6) step();
   endtask

   task automatic test_random();
      logic [22:0] obs, exp;
      for (int k = 0; k < 3000; k++) begin
         rst      = ($urandom_range(0, 399) == 0);
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
         out_en   = ($urandom_range(0, 24) == 0);
         addr_out = 1'($urandom_range(0, 1));
         io_out   = 16'($urandom);
         req_in   = ($urandom_range(0, 3) == 0);
         addr_in  = 1'($urandom_range(0, 1));
         step();
         obs = {itr, busy, ovf, id_data, 1'b0};
         exp = {m_fire, (m_fire || m_wait || m_gap > 0), m_ovf, 16'(m_id), 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random cyc %0d: itr/busy/ovf/id got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     k, itr, busy, ovf, id_data, exp[22], exp[21], exp[20:17], exp[16:1]);
         end
      end
      rst = 1'b0; irq = '0; out_en = 1'b0; req_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_masking();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
